// File: rtl/jag_cry_pkg.sv
// Shared CRY pixel definitions: field positions, RGB packing and requester ids.
package jag_cry_pkg;

    localparam int unsigned CRY_IDX_LSB = 8;
    localparam int unsigned CRY_Y_LSB   = 0;

    localparam logic REQ_OP   = 1'b0;
    localparam logic REQ_BLIT = 1'b1;

    // Packed as {R,G,B}, R in the most significant byte.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic logic [7:0] cry_idx(input logic [15:0] cry);
        return cry[CRY_IDX_LSB +: 8];
    endfunction

    function automatic logic [7:0] cry_y(input logic [15:0] cry);
        return cry[CRY_Y_LSB +: 8];
    endfunction

endpackage

// File: rtl/cry_rgb_sched_if.sv
// Pixel request and RGB result handshakes of the CRY lookup scheduler.
interface cry_rgb_sched_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_cry0;
    logic [15:0] req_cry1;
    logic        out_valid;
    logic        out_ready;
    logic        out_tag;
    logic [23:0] out_rgb;

    modport master (
        output req_valid, req_cry0, req_cry1, out_ready,
        input  req_ready, out_valid, out_tag, out_rgb
    );

    modport slave (
        input  req_valid, req_cry0, req_cry1, out_ready,
        output req_ready, out_valid, out_tag, out_rgb
    );
endinterface

// File: rtl/cry_scale.sv
// One colour component scaled by intensity with round-up: (base*y + 255) >> 8.
module cry_scale (
    input  logic [7:0] base,
    input  logic [7:0] y,
    output logic [7:0] comp
);
    logic [15:0] prod;
    logic [16:0] sum;

    always_comb begin
        prod = 16'(base) * 16'(y);
        sum  = {1'b0, prod} + 17'd255;
        // Carry out cannot occur for 8-bit operands; saturate rather than wrap.
        comp = sum[16] ? 8'hFF : sum[15:8];
    end
endmodule

// File: rtl/cry_rgb_sched.sv
// Two-requester scheduler for the shared CRY R/G/B ROMs; three-stage pipeline
// returning intensity-scaled, tagged 24-bit RGB with output backpressure.
module cry_rgb_sched
    import jag_cry_pkg::*;
#(
    parameter bit RR = 1'b1
) (
    input  logic                  sys_clk,
    input  logic                  resetl,
    cry_rgb_sched_if.slave        pix,
    output logic [7:0]            rom_a,
    input  logic [7:0]            rom_r_z,
    input  logic [7:0]            rom_g_z,
    input  logic [7:0]            rom_b_z,
    output logic                  busy
);

    logic        en;
    logic [1:0]  grant;
    logic        accept;
    logic        acc_tag;
    logic [15:0] acc_cry;
    logic        rr_ptr_q, rr_ptr_d;

    logic        s1_v_q, s1_tag_q;
    logic [7:0]  s1_y_q;
    logic [7:0]  rom_a_q;
    logic        s2_v_q, s2_tag_q;
    logic [7:0]  s2_y_q;

    logic        hold_v_q;
    rgb_t        hold_q;
    rgb_t        rom_data;
    rgb_t        base;
    rgb_t        scaled;
    logic [7:0]  sc_r, sc_g, sc_b;

    logic        out_valid_q, out_tag_q;
    rgb_t        out_rgb_q;

    assign en = !(out_valid_q && !pix.out_ready);

    // rr_ptr_q = 0 favours requester 0 when both are valid.
    always_comb begin
        grant = 2'b00;
        if (en && resetl) begin
            if (!RR || (pix.req_valid != 2'b11)) begin
                if (pix.req_valid[0]) begin
                    grant = 2'b01;
                end else if (pix.req_valid[1]) begin
                    grant = 2'b10;
                end
            end else begin
                grant = rr_ptr_q ? 2'b10 : 2'b01;
            end
        end
    end

    always_comb begin
        accept   = |grant;
        acc_tag  = grant[1] ? REQ_BLIT : REQ_OP;
        acc_cry  = grant[1] ? pix.req_cry1 : pix.req_cry0;
        rr_ptr_d = accept ? ~acc_tag : rr_ptr_q;
    end

    // The ROM keeps clocking during a stall and will re-read the stage-1
    // address, so the first stalled cycle's data is the only copy for the
    // stage-2 pixel; keep it until the pipeline moves again.
    always_comb begin
        rom_data = {rom_r_z, rom_g_z, rom_b_z};
        base     = hold_v_q ? hold_q : rom_data;
        scaled   = {sc_r, sc_g, sc_b};
    end

    cry_scale u_scale_r (.base(base.r), .y(s2_y_q), .comp(sc_r));
    cry_scale u_scale_g (.base(base.g), .y(s2_y_q), .comp(sc_g));
    cry_scale u_scale_b (.base(base.b), .y(s2_y_q), .comp(sc_b));

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            rr_ptr_q    <= 1'b0;
            s1_v_q      <= 1'b0;
            s1_tag_q    <= 1'b0;
            s1_y_q      <= 8'h00;
            rom_a_q     <= 8'h00;
            s2_v_q      <= 1'b0;
            s2_tag_q    <= 1'b0;
            s2_y_q      <= 8'h00;
            hold_v_q    <= 1'b0;
            hold_q      <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= 1'b0;
            out_rgb_q   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            hold_v_q <= !en;
            if (!en && !hold_v_q) begin
                hold_q <= rom_data;
            end
            if (en) begin
                s1_v_q <= accept;
                if (accept) begin
                    rom_a_q  <= cry_idx(acc_cry);
                    s1_y_q   <= cry_y(acc_cry);
                    s1_tag_q <= acc_tag;
                end
                s2_v_q      <= s1_v_q;
                s2_y_q      <= s1_y_q;
                s2_tag_q    <= s1_tag_q;
                out_valid_q <= s2_v_q;
                if (s2_v_q) begin
                    out_rgb_q <= scaled;
                    out_tag_q <= s2_tag_q;
                end
            end
        end
    end

    assign pix.req_ready = grant;
    assign pix.out_valid = out_valid_q;
    assign pix.out_tag   = out_tag_q;
    assign pix.out_rgb   = out_rgb_q;
    assign rom_a         = rom_a_q;
    assign busy          = s1_v_q | s2_v_q | out_valid_q;

endmodule

// File: tb/tb_cry_rgb_sched.sv
// Directed bench for cry_rgb_sched: ROM model, acceptance-order scoreboard and
// round-robin plus fixed-priority instances.
module tb_cry_rgb_sched;
    import jag_cry_pkg::*;

    logic sys_clk = 1'b0;
    logic resetl;
    always #5 sys_clk = ~sys_clk;

    cry_rgb_sched_if pix ();
    cry_rgb_sched_if pix_fp ();

    logic [7:0] rom_a, rom_r_z, rom_g_z, rom_b_z;
    logic       busy;
    logic [7:0] fp_rom_a;
    logic       fp_busy;

    cry_rgb_sched #(.RR(1'b1)) dut (
        .sys_clk (sys_clk),
        .resetl  (resetl),
        .pix     (pix),
        .rom_a   (rom_a),
        .rom_r_z (rom_r_z),
        .rom_g_z (rom_g_z),
        .rom_b_z (rom_b_z),
        .busy    (busy)
    );

    cry_rgb_sched #(.RR(1'b0)) dut_fp (
        .sys_clk (sys_clk),
        .resetl  (resetl),
        .pix     (pix_fp),
        .rom_a   (fp_rom_a),
        .rom_r_z (8'h00),
        .rom_g_z (8'h00),
        .rom_b_z (8'h00),
        .busy    (fp_busy)
    );

    function automatic logic [7:0] rom_r(input logic [7:0] a);
        case (a)
            8'h1F:   return 8'hFF;
            8'h2C:   return 8'hFC;
            default: return a ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [7:0] rom_g(input logic [7:0] a);
        case (a)
            8'h1F:   return 8'hFF;
            8'h2C:   return 8'hFC;
            default: return ~a;
        endcase
    endfunction

    function automatic logic [7:0] rom_b(input logic [7:0] a);
        case (a)
            8'h1F:   return 8'hDD;
            8'h2C:   return 8'hFC;
            default: return a + 8'h33;
        endcase
    endfunction

    always @(posedge sys_clk) begin
        rom_r_z <= rom_r(rom_a);
        rom_g_z <= rom_g(rom_a);
        rom_b_z <= rom_b(rom_a);
    end

    function automatic logic [7:0] scl(input logic [7:0] b, input logic [7:0] y);
        int p;
        p = (int'(b) * int'(y) + 255) / 256;
        return p[7:0];
    endfunction

    function automatic logic [23:0] exp_rgb(input logic [15:0] c);
        logic [7:0] a, y;
        a = c[15:8];
        y = c[7:0];
        return {scl(rom_r(a), y), scl(rom_g(a), y), scl(rom_b(a), y)};
    endfunction

    function automatic logic [15:0] bp_cry(input int i);
        return {8'(8'h30 + i * 7), 8'(8'h40 + i * 16)};
    endfunction

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_out   = 0;
    logic [24:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples the handshakes just before the next rising edge, then advances one clock.
    task automatic tick();
        logic [1:0]  acc;
        logic        ov;
        logic [24:0] e;
        #1;
        acc = pix.req_valid & pix.req_ready;
        ov  = pix.out_valid & pix.out_ready;
        if (acc[0]) exp_q.push_back({REQ_OP, exp_rgb(pix.req_cry0)});
        if (acc[1]) exp_q.push_back({REQ_BLIT, exp_rgb(pix.req_cry1)});
        if (ov) begin
            n_out++;
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_out", {7'b0, pix.out_tag, pix.out_rgb}, {7'b0, e});
            end
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        while (busy && k < 20) begin
            tick();
            k++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [23:0] hold;
        int          n0;

        resetl            = 1'b0;
        pix.req_valid     = 2'b11;
        pix.req_cry0      = 16'h0000;
        pix.req_cry1      = 16'h0000;
        pix.out_ready     = 1'b1;
        pix_fp.req_valid  = 2'b00;
        pix_fp.req_cry0   = 16'h1234;
        pix_fp.req_cry1   = 16'h5678;
        pix_fp.out_ready  = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_ready", 32'(pix.req_ready), 32'd0);
        check("rst_out_valid", 32'(pix.out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rom_a", 32'(rom_a), 32'd0);
        check("rst_rgb_tag", {7'b0, pix.out_tag, pix.out_rgb}, 32'd0);
        pix.req_valid = 2'b00;
        #3 resetl = 1'b1;
        @(posedge sys_clk);
        #1;

        // Single pixel from requester 0 and its latency.
        pix.req_valid = 2'b01;
        pix.req_cry0  = 16'h1FFF;
        #1;
        check("single_ready", 32'(pix.req_ready), 32'd1);
        tick();
        pix.req_valid = 2'b00;
        check("single_busy", 32'(busy), 32'd1);
        check("single_lat0", 32'(pix.out_valid), 32'd0);
        tick();
        check("single_lat1", 32'(pix.out_valid), 32'd0);
        tick();
        check("single_lat2", 32'(pix.out_valid), 32'd1);
        check("single_rgb", 32'(pix.out_rgb), 32'hFFFFDD);
        check("single_tag", 32'(pix.out_tag), 32'd0);
        drain("single_drain");

        // Intensity scaling on requester 1.
        pix.req_valid = 2'b10;
        pix.req_cry1  = 16'h2C80;
        #1;
        check("scale_ready", 32'(pix.req_ready), 32'd2);
        tick();
        pix.req_cry1 = 16'h2C00;
        tick();
        pix.req_valid = 2'b00;
        tick();
        check("scale_rgb", 32'(pix.out_rgb), 32'h7E7E7E);
        check("scale_tag", 32'(pix.out_tag), 32'd1);
        tick();
        check("scale_y0_rgb", 32'(pix.out_rgb), 32'h000000);
        drain("scale_drain");

        // Backpressure mid-stream.
        n0 = n_out;
        pix.req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            pix.req_cry0 = bp_cry(i);
            #1;
            check("bp_ready_pre", 32'(pix.req_ready), 32'd1);
            tick();
        end
        pix.req_cry0  = bp_cry(3);
        pix.out_ready = 1'b0;
        #1;
        hold = pix.out_rgb;
        check("bp_hold_val", 32'(hold), 32'(exp_rgb(bp_cry(0))));
        for (int i = 0; i < 4; i++) begin
            check("bp_stall_ready", 32'(pix.req_ready), 32'd0);
            tick();
            check("bp_stall_valid", 32'(pix.out_valid), 32'd1);
            check("bp_stall_rgb", 32'(pix.out_rgb), 32'(hold));
        end
        pix.out_ready = 1'b1;
        for (int i = 3; i < 6; i++) begin
            pix.req_cry0 = bp_cry(i);
            #1;
            check("bp_ready_post", 32'(pix.req_ready), 32'd1);
            tick();
        end
        pix.req_valid = 2'b00;
        drain("bp_drain");
        check("bp_count", 32'(n_out - n0), 32'd6);
        check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset with three pixels in flight.
        pix.req_valid = 2'b01;
        for (int i = 0; i < 3; i++) begin
            pix.req_cry0 = {8'(8'h50 + i), 8'h90};
            tick();
        end
        pix.req_valid = 2'b00;
        check("rst_mid_busy_before", 32'(busy), 32'd1);
        #2 resetl = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(pix.out_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(posedge sys_clk);
        #3 resetl = 1'b1;
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_no_stale", 32'(pix.out_valid), 32'd0);
        end

        // Contention: round-robin alternates, fixed priority starves requester 1.
        pix.req_valid    = 2'b11;
        pix_fp.req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            pix.req_cry0 = {8'(8'h60 + k), 8'hC0};
            pix.req_cry1 = {8'(8'hA0 + k), 8'h70};
            #1;
            check("rr_grant", 32'(pix.req_ready), (k % 2 == 1) ? 32'd2 : 32'd1);
            check("fp_grant", 32'(pix_fp.req_ready), 32'd1);
            tick();
        end
        pix.req_valid    = 2'b00;
        pix_fp.req_valid = 2'b10;
        #1;
        check("fp_req1_after", 32'(pix_fp.req_ready), 32'd2);
        pix_fp.req_valid = 2'b00;
        drain("rr_drain");
        check("rr_sb_empty", 32'(exp_q.size()), 32'd0);

        // Back-to-back stream from requester 1.
        pix.req_valid = 2'b10;
        n0 = n_out;
        for (int i = 0; i < 16; i++) begin
            pix.req_cry1 = {8'(i * 17), 8'(8'hF0 - i * 9)};
            #1;
            check("b2b_ready", 32'(pix.req_ready), 32'd2);
            tick();
        end
        pix.req_valid = 2'b00;
        repeat (3) tick();
        check("b2b_count", 32'(n_out - n0), 32'd16);
        check("b2b_idle", 32'(busy), 32'd0);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
